// File: rtl/wr_sched_if.sv
// Write-channel handshake bundle between two AXI masters, three slaves and
// the write scheduler. Payload muxes are external; only valid/ready, WLAST,
// AWADDR/AWLEN and the steering outputs travel here.
//   slave  : scheduler view (takes master/slave handshakes, drives gated ones)
//   master : environment view (drives masters and slave responses)
interface wr_sched_if;
  // Master-side inputs to the scheduler
  logic        AWVALID_M0, AWVALID_M1;
  logic [31:0] AWADDR_M0,  AWADDR_M1;
  logic [3:0]  AWLEN_M0,   AWLEN_M1;
  logic        WVALID_M0,  WVALID_M1;
  logic        WLAST_M0,   WLAST_M1;
  logic        BREADY_M0,  BREADY_M1;
  // Slave-side inputs to the scheduler
  logic        AWREADY_S0, AWREADY_S1, AWREADY_S2;
  logic        WREADY_S0,  WREADY_S1,  WREADY_S2;
  logic        BVALID_S0,  BVALID_S1,  BVALID_S2;
  // Gated handshakes toward the slaves
  logic        AWVALID_S0, AWVALID_S1, AWVALID_S2;
  logic        WVALID_S0,  WVALID_S1,  WVALID_S2;
  logic        BREADY_S0,  BREADY_S1,  BREADY_S2;
  // Gated handshakes toward the masters
  logic        AWREADY_M0, AWREADY_M1;
  logic        WREADY_M0,  WREADY_M1;
  logic        BVALID_M0,  BVALID_M1;
  // Steering and status
  logic [1:0]  grant;
  logic [2:0]  slave_sel;
  logic        proto_err;

  modport slave (
    input  AWVALID_M0, AWVALID_M1, AWADDR_M0, AWADDR_M1, AWLEN_M0, AWLEN_M1,
           WVALID_M0, WVALID_M1, WLAST_M0, WLAST_M1, BREADY_M0, BREADY_M1,
           AWREADY_S0, AWREADY_S1, AWREADY_S2,
           WREADY_S0, WREADY_S1, WREADY_S2,
           BVALID_S0, BVALID_S1, BVALID_S2,
    output AWVALID_S0, AWVALID_S1, AWVALID_S2,
           WVALID_S0, WVALID_S1, WVALID_S2,
           BREADY_S0, BREADY_S1, BREADY_S2,
           AWREADY_M0, AWREADY_M1, WREADY_M0, WREADY_M1, BVALID_M0, BVALID_M1,
           grant, slave_sel, proto_err
  );

  modport master (
    output AWVALID_M0, AWVALID_M1, AWADDR_M0, AWADDR_M1, AWLEN_M0, AWLEN_M1,
           WVALID_M0, WVALID_M1, WLAST_M0, WLAST_M1, BREADY_M0, BREADY_M1,
           AWREADY_S0, AWREADY_S1, AWREADY_S2,
           WREADY_S0, WREADY_S1, WREADY_S2,
           BVALID_S0, BVALID_S1, BVALID_S2,
    input  AWVALID_S0, AWVALID_S1, AWVALID_S2,
           WVALID_S0, WVALID_S1, WVALID_S2,
           BREADY_S0, BREADY_S1, BREADY_S2,
           AWREADY_M0, AWREADY_M1, WREADY_M0, WREADY_M1, BVALID_M0, BVALID_M1,
           grant, slave_sel, proto_err
  );
endinterface

// File: rtl/wr_sched.sv
// Write-channel scheduler: round-robin grant of M0/M1, address decode to
// S0/S1/S2 (S2 default), strict AW -> W -> B sequencing, burst-length check.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - wr_sched_if.slave: master/slave handshakes in, gated handshakes,
//          grant (one-hot master), slave_sel (one-hot slave), proto_err out
module wr_sched #(
  parameter logic [31:0] S0_BASE = 32'h0000_0000,
  parameter logic [31:0] S1_BASE = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,
  wr_sched_if.slave   bus
);

  localparam int unsigned NM = 2;
  localparam int unsigned NS = 3;
  localparam int unsigned LW = 4;
  localparam logic [31:0] REGION_MASK = 32'hFFFF_0000;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t          r_state, w_state_nxt;
  logic [NM-1:0]   r_grant, w_grant_nxt;
  logic [NM-1:0]   r_rr_last, w_rr_last_nxt;
  logic [NS-1:0]   r_slave_sel, w_slave_sel_nxt;
  logic [LW-1:0]   r_len_q, w_len_q_nxt;
  logic [LW-1:0]   r_beat_cnt, w_beat_cnt_nxt;
  logic            r_proto_err, w_proto_err_nxt;

  // One-hot region decode; XOR/mask compares the upper half-word only
  function automatic logic [NS-1:0] f_decode(input logic [31:0] addr);
    if (((addr ^ S0_BASE) & REGION_MASK) == 32'h0)      return 3'b001;
    else if (((addr ^ S1_BASE) & REGION_MASK) == 32'h0) return 3'b010;
    else                                                return 3'b100;
  endfunction

  // Arbitration candidate: on a tie the master that did not go last wins
  logic [NM-1:0] w_req, w_pick;
  logic [31:0]   w_pick_addr;
  logic [LW-1:0] w_pick_len;
  assign w_req       = {bus.AWVALID_M1, bus.AWVALID_M0};
  assign w_pick      = (&w_req) ? ~r_rr_last : w_req;
  assign w_pick_addr = w_pick[1] ? bus.AWADDR_M1 : bus.AWADDR_M0;
  assign w_pick_len  = w_pick[1] ? bus.AWLEN_M1  : bus.AWLEN_M0;

  // Live handshakes of the granted master and the selected slave
  logic w_awv_m, w_wv_m, w_wlast_m, w_br_m;
  logic w_awr_s, w_wr_s, w_bv_s;
  assign w_awv_m   = |(r_grant & {bus.AWVALID_M1, bus.AWVALID_M0});
  assign w_wv_m    = |(r_grant & {bus.WVALID_M1,  bus.WVALID_M0});
  assign w_wlast_m = |(r_grant & {bus.WLAST_M1,   bus.WLAST_M0});
  assign w_br_m    = |(r_grant & {bus.BREADY_M1,  bus.BREADY_M0});
  assign w_awr_s   = |(r_slave_sel & {bus.AWREADY_S2, bus.AWREADY_S1, bus.AWREADY_S0});
  assign w_wr_s    = |(r_slave_sel & {bus.WREADY_S2,  bus.WREADY_S1,  bus.WREADY_S0});
  assign w_bv_s    = |(r_slave_sel & {bus.BVALID_S2,  bus.BVALID_S1,  bus.BVALID_S0});

  // State and control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_slave_sel <= '0;
      r_len_q     <= '0;
      r_beat_cnt  <= '0;
      r_rr_last   <= 2'b10;
      r_proto_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_slave_sel <= w_slave_sel_nxt;
      r_len_q     <= w_len_q_nxt;
      r_beat_cnt  <= w_beat_cnt_nxt;
      r_rr_last   <= w_rr_last_nxt;
      r_proto_err <= w_proto_err_nxt;
    end
  end

  // Next-state and control
  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_slave_sel_nxt = r_slave_sel;
    w_len_q_nxt     = r_len_q;
    w_beat_cnt_nxt  = r_beat_cnt;
    w_rr_last_nxt   = r_rr_last;
    w_proto_err_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_grant_nxt     = '0;
        w_slave_sel_nxt = '0;
        if (|w_req) begin
          w_grant_nxt     = w_pick;
          w_slave_sel_nxt = f_decode(w_pick_addr);
          w_len_q_nxt     = w_pick_len;
          w_state_nxt     = ADDR;
        end
      end
      ADDR: begin
        if (w_awv_m && w_awr_s) begin
          w_beat_cnt_nxt = '0;
          w_state_nxt    = DATA;
        end
      end
      DATA: begin
        if (w_wv_m && w_wr_s) begin
          if (w_wlast_m) begin
            w_proto_err_nxt = (r_beat_cnt != r_len_q);
            w_state_nxt     = RESP;
          end else if (r_beat_cnt == r_len_q) begin
            // Overlong burst: flag every extra beat, counter saturates
            w_proto_err_nxt = 1'b1;
          end else begin
            w_beat_cnt_nxt = LW'(r_beat_cnt + 4'd1);
          end
        end
      end
      RESP: begin
        if (w_br_m && w_bv_s) begin
          w_rr_last_nxt   = r_grant;
          w_grant_nxt     = '0;
          w_slave_sel_nxt = '0;
          w_state_nxt     = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Gated handshakes: combinational from phase, steering and live inputs
  logic w_ph_addr, w_ph_data, w_ph_resp;
  assign w_ph_addr = (r_state == ADDR);
  assign w_ph_data = (r_state == DATA);
  assign w_ph_resp = (r_state == RESP);

  logic [NS-1:0] w_awv_s, w_wv_s, w_br_s;
  logic [NM-1:0] w_awr_m, w_wr_m, w_bv_m;
  assign w_awv_s = (w_ph_addr && w_awv_m) ? r_slave_sel : '0;
  assign w_wv_s  = (w_ph_data && w_wv_m)  ? r_slave_sel : '0;
  assign w_br_s  = (w_ph_resp && w_br_m)  ? r_slave_sel : '0;
  assign w_awr_m = (w_ph_addr && w_awr_s) ? r_grant : '0;
  assign w_wr_m  = (w_ph_data && w_wr_s)  ? r_grant : '0;
  assign w_bv_m  = (w_ph_resp && w_bv_s)  ? r_grant : '0;

  assign {bus.AWVALID_S2, bus.AWVALID_S1, bus.AWVALID_S0} = w_awv_s;
  assign {bus.WVALID_S2,  bus.WVALID_S1,  bus.WVALID_S0}  = w_wv_s;
  assign {bus.BREADY_S2,  bus.BREADY_S1,  bus.BREADY_S0}  = w_br_s;
  assign {bus.AWREADY_M1, bus.AWREADY_M0} = w_awr_m;
  assign {bus.WREADY_M1,  bus.WREADY_M0}  = w_wr_m;
  assign {bus.BVALID_M1,  bus.BVALID_M0}  = w_bv_m;

  assign bus.grant     = r_grant;
  assign bus.slave_sel = r_slave_sel;
  assign bus.proto_err = r_proto_err;

endmodule
